// File: rtl/axis_pkt_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkt_pkg
// Shared constants for the AXI-Stream packet generator slice.
//   bpb_of(dw)   : bytes per beat for a stream of dw bits
//   len_msb(dw)  : top bit of the 16-bit length field in a command beat
//   len_lsb(dw)  : bottom bit of the 16-bit length field in a command beat
//   ST_IDLE/ST_SEND : generator FSM encoding
// ---------------------------------------------------------------------------
package axis_pkt_pkg;

  localparam int LEN_W = 16;

  function automatic int bpb_of(input int dw);
    return dw / 8;
  endfunction

  function automatic int len_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int len_lsb(input int dw);
    return dw - LEN_W;
  endfunction

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/axis_keep_mask.sv
// ---------------------------------------------------------------------------
// axis_keep_mask
// Turns a count of bytes still to send into a contiguous TKEEP mask.
// Bits [remaining-1:0] are set; once remaining reaches a full beat the mask
// saturates to all ones.
// Ports:
//   remaining  in  16      bytes left in the packet
//   keep_mask  out DW/8    contiguous byte-enable mask from bit 0
// ---------------------------------------------------------------------------
module axis_keep_mask
  import axis_pkt_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic [15:0]     remaining,
  output logic [DW/8-1:0] keep_mask
);

  localparam int BPB = bpb_of(DW);

  // A byte lane is enabled when its index is below the remaining count,
  // which naturally gives all ones for remaining >= BPB.
  always_comb begin
    keep_mask = '0;
    for (int k = 0; k < BPB; k++) begin
      keep_mask[k] = (16'(k) < remaining);
    end
  end

endmodule

// File: rtl/axis_packet_generator.sv
// ---------------------------------------------------------------------------
// axis_packet_generator
// Accepts packet-length commands and emits one AXI-Stream packet per command
// of exactly that many bytes. Packet byte i carries i[7:0]; TKEEP is
// contiguous from bit 0 and TLAST marks the final beat.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   cmd_tdata/tvalid/tready    command stream, length in top 16 bits
//   axis_out_tdata/tkeep/tlast/tvalid/tready  generated packet stream
//   packets_sent       16-bit count of completed packets (wraps)
//   busy               high while a packet is in progress
//   err_zero_len       one-cycle pulse when a zero-length command is dropped
// ---------------------------------------------------------------------------
module axis_packet_generator
  import axis_pkt_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [DW-1:0]   cmd_tdata,
  input  logic            cmd_tvalid,
  output logic            cmd_tready,
  output logic [DW-1:0]   axis_out_tdata,
  output logic [DW/8-1:0] axis_out_tkeep,
  output logic            axis_out_tlast,
  output logic            axis_out_tvalid,
  input  logic            axis_out_tready,
  output logic [15:0]     packets_sent,
  output logic            busy,
  output logic            err_zero_len
);

  localparam int          BPB     = bpb_of(DW);
  localparam int          LEN_MSB = len_msb(DW);
  localparam int          LEN_LSB = len_lsb(DW);
  localparam logic [15:0] BPB16   = 16'(BPB);

  logic [0:0]      state;
  logic [15:0]     remaining;
  logic [15:0]     offset;
  logic [15:0]     cmd_len;
  logic [15:0]     load_len;
  logic [15:0]     load_off;
  logic [BPB-1:0]  load_keep;
  logic [DW-1:0]   load_data;
  logic            cmd_fire;
  logic            out_fire;
  logic            unused_cmd_bits;

  assign cmd_len         = cmd_tdata[LEN_MSB:LEN_LSB];
  assign unused_cmd_bits = ^cmd_tdata[LEN_LSB-1:0];

  assign cmd_tready = resetn & (state == ST_IDLE);
  assign busy       = (state == ST_SEND);
  assign cmd_fire   = cmd_tvalid & cmd_tready;
  assign out_fire   = axis_out_tvalid & axis_out_tready;

  // The beat to load next is either the first beat of a fresh command
  // (IDLE) or the beat following the one being handed off (SEND). In SEND
  // on the last beat this underflows, but the value is never loaded then.
  always_comb begin
    load_len = cmd_len;
    load_off = '0;
    if (state == ST_SEND) begin
      load_len = remaining - BPB16;
      load_off = offset + BPB16;
    end
  end

  axis_keep_mask #(
    .DW(DW)
  ) u_keep_mask (
    .remaining (load_len),
    .keep_mask (load_keep)
  );

  // Byte lanes outside the keep mask are forced to zero so the stream is
  // fully deterministic.
  always_comb begin
    load_data = '0;
    for (int k = 0; k < BPB; k++) begin
      if (load_keep[k]) begin
        load_data[8*k +: 8] = 8'(load_off + 16'(k));
      end
    end
  end

  // Main FSM and output registers. Output beats are registered, so the
  // next beat is loaded on the same edge that retires the current one,
  // giving one beat per cycle under continuous ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      remaining       <= '0;
      offset          <= '0;
      axis_out_tdata  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tvalid <= 1'b0;
      packets_sent    <= '0;
      err_zero_len    <= 1'b0;
    end else begin
      err_zero_len <= 1'b0;
      if (state == ST_IDLE) begin
        if (cmd_fire) begin
          if (cmd_len == 16'd0) begin
            err_zero_len <= 1'b1;
          end else begin
            remaining       <= load_len;
            offset          <= load_off;
            axis_out_tdata  <= load_data;
            axis_out_tkeep  <= load_keep;
            axis_out_tlast  <= (load_len <= BPB16);
            axis_out_tvalid <= 1'b1;
            state           <= ST_SEND;
          end
        end
      end else begin
        if (out_fire) begin
          if (axis_out_tlast) begin
            packets_sent    <= packets_sent + 16'd1;
            axis_out_tvalid <= 1'b0;
            state           <= ST_IDLE;
          end else begin
            remaining      <= load_len;
            offset         <= load_off;
            axis_out_tdata <= load_data;
            axis_out_tkeep <= load_keep;
            axis_out_tlast <= (load_len <= BPB16);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_generator.sv
// ---------------------------------------------------------------------------
// tb_axis_packet_generator
// Directed self-checking bench for axis_packet_generator at DW=512.
// ---------------------------------------------------------------------------
module tb_axis_packet_generator;

  localparam int DW  = 512;
  localparam int BPB = 64;

  logic            clk;
  logic            resetn;
  logic [DW-1:0]   cmd_tdata;
  logic            cmd_tvalid;
  logic            cmd_tready;
  logic [DW-1:0]   axis_out_tdata;
  logic [BPB-1:0]  axis_out_tkeep;
  logic            axis_out_tlast;
  logic            axis_out_tvalid;
  logic            axis_out_tready;
  logic [15:0]     packets_sent;
  logic            busy;
  logic            err_zero_len;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]  cap_data [4];
  logic [BPB-1:0] cap_keep [4];
  logic           cap_last [4];

  axis_packet_generator #(
    .DW(DW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .cmd_tdata       (cmd_tdata),
    .cmd_tvalid      (cmd_tvalid),
    .cmd_tready      (cmd_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .packets_sent    (packets_sent),
    .busy            (busy),
    .err_zero_len    (err_zero_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat contents: byte k holds (off+k) mod 256 for k < nbytes.
  function automatic logic [DW-1:0] pattern(input int off, input int nbytes);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < BPB; k++) begin
      if (k < nbytes) d[8*k +: 8] = 8'((off + k) % 256);
    end
    return d;
  endfunction

  function automatic logic [BPB-1:0] ones(input int n);
    logic [BPB-1:0] m;
    m = '0;
    for (int k = 0; k < BPB; k++) begin
      if (k < n) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted; returns at the sample
  // point just after the accepting edge.
  task automatic send_cmd(input int len);
    int wait_cycles;
    wait_cycles = 0;
    cmd_tdata = '0;
    cmd_tdata[DW-1 -: 16] = 16'(len);
    cmd_tvalid = 1'b1;
    while (!cmd_tready && wait_cycles < 2000) begin
      step();
      wait_cycles++;
    end
    checks++;
    if (cmd_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_accept_timeout len=%0d got ready=%b want 1", len, cmd_tready);
    end
    step();
    cmd_tvalid = 1'b0;
  endtask

  // Record beats of one packet with tready held high.
  task automatic capture_packet(input int max_cycles, output int nbeats, output bit done);
    nbeats = 0;
    done = 1'b0;
    axis_out_tready = 1'b1;
    for (int c = 0; c < max_cycles && !done; c++) begin
      if (axis_out_tvalid) begin
        if (nbeats < 4) begin
          cap_data[nbeats] = axis_out_tdata;
          cap_keep[nbeats] = axis_out_tkeep;
          cap_last[nbeats] = axis_out_tlast;
        end
        nbeats++;
        if (axis_out_tlast) done = 1'b1;
      end
      step();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cmd_tvalid = 1'b0;
    cmd_tdata = '0;
    axis_out_tready = 1'b0;
    repeat (3) step();
    checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b want 0", axis_out_tvalid); end
    checks++; if (axis_out_tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata got %h want 0", axis_out_tdata); end
    checks++; if (axis_out_tkeep !== '0) begin errors++; $display("[TB] FAIL reset_tkeep got %h want 0", axis_out_tkeep); end
    checks++; if (axis_out_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %b want 0", axis_out_tlast); end
    checks++; if (packets_sent !== 16'd0) begin errors++; $display("[TB] FAIL reset_packets_sent got %0d want 0", packets_sent); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (err_zero_len !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err_zero_len); end
    checks++; if (cmd_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_tready got %b want 0", cmd_tready); end
    resetn = 1'b1;
    step();
    checks++; if (cmd_tready !== 1'b1) begin errors++; $display("[TB] FAIL idle_cmd_tready got %b want 1", cmd_tready); end
  endtask

  task automatic test_single_beat();
    axis_out_tready = 1'b1;
    send_cmd(64);
    checks++; if (axis_out_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency_tvalid got %b want 1", axis_out_tvalid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", busy); end
    checks++; if (axis_out_tkeep !== {BPB{1'b1}}) begin errors++; $display("[TB] FAIL single_tkeep got %h want all ones", axis_out_tkeep); end
    checks++; if (axis_out_tlast !== 1'b1) begin errors++; $display("[TB] FAIL single_tlast got %b want 1", axis_out_tlast); end
    checks++; if (axis_out_tdata !== pattern(0, 64)) begin errors++; $display("[TB] FAIL single_tdata got %h want %h", axis_out_tdata, pattern(0, 64)); end
    step();
    checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_end_tvalid got %b want 0", axis_out_tvalid); end
    checks++; if (packets_sent !== 16'd1) begin errors++; $display("[TB] FAIL single_packets_sent got %0d want 1", packets_sent); end
  endtask

  task automatic test_multi_beat();
    int n;
    bit done;
    logic [DW-1:0] exp_last;
    exp_last = '0;
    exp_last[7:0]  = 8'h80;
    exp_last[15:8] = 8'h81;
    axis_out_tready = 1'b1;
    send_cmd(130);
    capture_packet(20, n, done);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL multi_timeout got done=%b want 1", done); end
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL multi_beats got %0d want 3", n); end
    checks++; if (cap_keep[0] !== {BPB{1'b1}} || cap_keep[1] !== {BPB{1'b1}}) begin errors++; $display("[TB] FAIL multi_keep01 got %h %h want all ones", cap_keep[0], cap_keep[1]); end
    checks++; if (cap_keep[2] !== 64'h3) begin errors++; $display("[TB] FAIL multi_keep2 got %h want 3", cap_keep[2]); end
    checks++; if ({cap_last[0], cap_last[1], cap_last[2]} !== 3'b001) begin errors++; $display("[TB] FAIL multi_tlast got %b%b%b want 001", cap_last[0], cap_last[1], cap_last[2]); end
    checks++; if (cap_data[1] !== pattern(64, 64)) begin errors++; $display("[TB] FAIL multi_data1 got %h want %h", cap_data[1], pattern(64, 64)); end
    checks++; if (cap_data[2] !== exp_last) begin errors++; $display("[TB] FAIL multi_data2 got %h want %h", cap_data[2], exp_last); end
    checks++; if (packets_sent !== 16'd2) begin errors++; $display("[TB] FAIL multi_packets_sent got %0d want 2", packets_sent); end
  endtask

  task automatic test_zero_length();
    axis_out_tready = 1'b1;
    send_cmd(0);
    checks++; if (err_zero_len !== 1'b1) begin errors++; $display("[TB] FAIL zero_err_pulse got %b want 1", err_zero_len); end
    checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL zero_no_beat got %b want 0", axis_out_tvalid); end
    step();
    checks++; if (err_zero_len !== 1'b0) begin errors++; $display("[TB] FAIL zero_err_width got %b want 0", err_zero_len); end
    checks++; if (packets_sent !== 16'd2) begin errors++; $display("[TB] FAIL zero_packets_sent got %0d want 2", packets_sent); end
    send_cmd(1);
    checks++; if (axis_out_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL len1_tvalid got %b want 1", axis_out_tvalid); end
    checks++; if (axis_out_tkeep !== 64'h1) begin errors++; $display("[TB] FAIL len1_tkeep got %h want 1", axis_out_tkeep); end
    checks++; if (axis_out_tdata !== '0) begin errors++; $display("[TB] FAIL len1_tdata got %h want 0", axis_out_tdata); end
    checks++; if (axis_out_tlast !== 1'b1) begin errors++; $display("[TB] FAIL len1_tlast got %b want 1", axis_out_tlast); end
    step();
    checks++; if (packets_sent !== 16'd3) begin errors++; $display("[TB] FAIL len1_packets_sent got %0d want 3", packets_sent); end
  endtask

  task automatic test_backpressure();
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int b;
    int rem;
    int nb;
    axis_out_tready = 1'b0;
    send_cmd(200);
    b = 0;
    for (int i = 0; i < 7; i++) begin
      axis_out_tready = pat[i][0];
      rem = 200 - 64 * b;
      nb = (rem < 64) ? rem : 64;
      checks++; if (axis_out_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_tvalid cyc=%0d got %b want 1", i, axis_out_tvalid); end
      checks++; if (axis_out_tdata !== pattern(64 * b, nb)) begin errors++; $display("[TB] FAIL bp_tdata cyc=%0d got %h want %h", i, axis_out_tdata, pattern(64 * b, nb)); end
      checks++; if (axis_out_tkeep !== ones(nb)) begin errors++; $display("[TB] FAIL bp_tkeep cyc=%0d got %h want %h", i, axis_out_tkeep, ones(nb)); end
      checks++; if (axis_out_tlast !== (rem <= 64)) begin errors++; $display("[TB] FAIL bp_tlast cyc=%0d got %b want %b", i, axis_out_tlast, (rem <= 64)); end
      if (b == 3) begin
        checks++; if (axis_out_tkeep !== 64'hFF || axis_out_tdata[7:0] !== 8'hC0) begin errors++; $display("[TB] FAIL bp_last_beat got keep=%h byte0=%h want FF C0", axis_out_tkeep, axis_out_tdata[7:0]); end
      end
      if (pat[i] == 1) b++;
      step();
    end
    checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_end_tvalid got %b want 0", axis_out_tvalid); end
    checks++; if (packets_sent !== 16'd4) begin errors++; $display("[TB] FAIL bp_packets_sent got %0d want 4", packets_sent); end
  endtask

  task automatic test_back_to_back();
    int accepts, pkt, n1, n2, gap, t1;
    logic [BPB-1:0] keep1_last, keep2_last;
    logic [7:0] p1b4, p2_byte0;
    accepts = 0; pkt = 0; n1 = 0; n2 = 0; gap = 0; t1 = 0;
    keep1_last = '0; keep2_last = '0; p1b4 = 8'hXX; p2_byte0 = 8'hXX;
    axis_out_tready = 1'b1;
    cmd_tdata = '0;
    cmd_tdata[DW-1 -: 16] = 16'd300;
    cmd_tvalid = 1'b1;
    for (int c = 0; c < 1300 && pkt != 2; c++) begin
      if (cmd_tvalid && cmd_tready) accepts++;
      if (axis_out_tvalid) begin
        if (pkt == 0) begin
          if (n1 == 4) p1b4 = axis_out_tdata[7:0];
          if (axis_out_tlast) begin
            t1++;
            keep1_last = axis_out_tkeep;
            pkt = 1;
          end
          n1++;
        end else begin
          n2++;
          if (axis_out_tlast) begin
            keep2_last = axis_out_tkeep;
            p2_byte0 = axis_out_tdata[7:0];
            pkt = 2;
          end
        end
      end else if (pkt == 1) begin
        gap++;
      end
      step();
      if (accepts == 1) cmd_tdata[DW-1 -: 16] = 16'hFFFF;
      else if (accepts >= 2) cmd_tvalid = 1'b0;
    end
    cmd_tvalid = 1'b0;
    checks++; if (pkt != 2) begin errors++; $display("[TB] FAIL b2b_timeout got pkt=%0d want 2", pkt); end
    checks++; if (n1 != 5) begin errors++; $display("[TB] FAIL b2b_p1_beats got %0d want 5", n1); end
    checks++; if (p1b4 !== 8'h00) begin errors++; $display("[TB] FAIL b2b_p1_beat4_byte0 got %h want 00", p1b4); end
    checks++; if (keep1_last !== 64'h0000_0FFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_p1_keep got %h want 00000FFFFFFFFFFF", keep1_last); end
    checks++; if (gap != 1) begin errors++; $display("[TB] FAIL b2b_gap got %0d want 1", gap); end
    checks++; if (n2 != 1024) begin errors++; $display("[TB] FAIL b2b_p2_beats got %0d want 1024", n2); end
    checks++; if (keep2_last !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_p2_keep got %h want 7FFFFFFFFFFFFFFF", keep2_last); end
    checks++; if (p2_byte0 !== 8'hC0) begin errors++; $display("[TB] FAIL b2b_p2_byte0 got %h want C0", p2_byte0); end
    checks++; if (packets_sent !== 16'd6) begin errors++; $display("[TB] FAIL b2b_packets_sent got %0d want 6", packets_sent); end
    checks++; if (accepts != 2) begin errors++; $display("[TB] FAIL b2b_accepts got %0d want 2", accepts); end
  endtask

  task automatic test_reset_mid_packet();
    axis_out_tready = 1'b1;
    send_cmd(640);
    step();
    step();
    checks++; if (axis_out_tvalid !== 1'b1 || axis_out_tdata[7:0] !== 8'h80) begin errors++; $display("[TB] FAIL midrst_beat3 got valid=%b byte0=%h want 1 80", axis_out_tvalid, axis_out_tdata[7:0]); end
    resetn = 1'b0;
    step();
    checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tvalid got %b want 0", axis_out_tvalid); end
    checks++; if (axis_out_tlast !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tlast got %b want 0", axis_out_tlast); end
    checks++; if (packets_sent !== 16'd0) begin errors++; $display("[TB] FAIL midrst_packets_sent got %0d want 0", packets_sent); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    checks++; if (cmd_tready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cmd_tready got %b want 0", cmd_tready); end
    resetn = 1'b1;
    step();
    send_cmd(64);
    checks++; if (axis_out_tvalid !== 1'b1 || axis_out_tlast !== 1'b1) begin errors++; $display("[TB] FAIL postrst_beat got valid=%b last=%b want 1 1", axis_out_tvalid, axis_out_tlast); end
    checks++; if (axis_out_tdata !== pattern(0, 64)) begin errors++; $display("[TB] FAIL postrst_tdata got %h want %h", axis_out_tdata, pattern(0, 64)); end
    step();
    checks++; if (packets_sent !== 16'd1) begin errors++; $display("[TB] FAIL postrst_packets_sent got %0d want 1", packets_sent); end
  endtask

  initial begin
    $display("[TB] starting axis_packet_generator bench");
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_zero_length();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/axis_packet_generator.md
# axis_packet_generator

Transmit-side counterpart to the packet counter/measurement path. Accepts packet-length commands on an AXI-Stream command port, using the same beat format the counter emits: a 16-bit byte count in the top bits of a DW-wide word. For each command it produces one AXI-Stream packet of exactly that many bytes, with a deterministic byte pattern, contiguous TKEEP and correct TLAST. Used as a stimulus source ahead of the packet counter and FIFO path, so measured sizes can be checked against requested sizes.

## Interface
- DW, 512: stream data width in bits; multiple of 8; DW/8 (BPB, bytes per beat) a power of two, 8..64.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- cmd_tdata  in  DW  command beat; requested length L in bits [DW-1:DW-16]; other bits ignored.
- cmd_tvalid  in  1  command valid.
- cmd_tready  out  1  command ready.
- axis_out_tdata  out  DW  packet data; byte k at bits [8k+7:8k].
- axis_out_tkeep  out  DW/8  byte enables.
- axis_out_tlast  out  1  last beat of packet.
- axis_out_tvalid  out  1  beat valid.
- axis_out_tready  in  1  downstream ready.
- packets_sent  out  16  count of completed packets; wraps 65535 -> 0.
- busy  out  1  high while a packet is in progress.
- err_zero_len  out  1  one-cycle pulse when an L=0 command is dropped.

## Operation
- States: IDLE and SEND.
- IDLE:
  - cmd_tready = resetn & (state==IDLE), combinational.
  - On cmd handshake with L=0: drop the command, pulse err_zero_len, stay in IDLE.
  - On cmd handshake with L>0: set remaining=L and offset=0, load the first beat into the output registers, go to SEND.
- SEND:
  - axis_out_tvalid=1 and busy=1.
  - Packet byte i carries value i[7:0], wrapping mod 256.
  - Beat byte k = (offset+k)[7:0] when tkeep[k]=1, else 0x00.
  - tkeep: all ones if remaining >= BPB; otherwise the low `remaining` bits set, contiguous from bit 0.
  - tlast = (remaining <= BPB).
- Handshake on axis_out_tvalid & axis_out_tready:
  - Not the last beat: remaining -= BPB, offset += BPB, load the next beat.
  - Last beat: packets_sent += 1, tvalid <= 0, go to IDLE.
- Beat count per packet = ceil(L/BPB). For L=65535 and BPB=64 this is 1024 beats.
- Widths: remaining and offset are 16-bit unsigned. No overflow is possible, since offset stays below L.

## Timing
- Reset values: axis_out_tvalid 0, tdata 0, tkeep 0, tlast 0, packets_sent 0, busy 0, err_zero_len 0, state IDLE. cmd_tready is 0 while resetn=0.
- Latency: a command accepted at edge N presents its first beat (tvalid=1) after edge N, i.e. in cycle N+1.
- err_zero_len is high for exactly the cycle after the L=0 handshake.
- Throughput: one beat per cycle while axis_out_tready=1.
- Inter-packet gap: exactly one idle cycle, because a command is accepted only in IDLE.
- Backpressure: while tvalid=1 and tready=0, tdata, tkeep and tlast hold stable. tvalid never drops before the handshake.
- Simultaneous events: cmd_tvalid asserted during SEND is ignored (cmd_tready=0) until IDLE. A last-beat handshake and a new command in the same cycle cannot both be accepted.
- Reset mid-packet: at the next edge tvalid=0 and state=IDLE. The partial packet is abandoned without TLAST and packets_sent clears to 0.

## Structure
- Package axis_pkt_pkg:
  - BPB constant function of DW.
  - LEN_MSB/LEN_LSB (DW-1, DW-16).
  - State encoding IDLE/SEND.
- Sub-module axis_keep_mask: combinational. Input: 16-bit remaining. Output: DW/8-bit contiguous mask (saturates to all ones). Reused by the beat-data zeroing logic.
- The remaining logic (FSM, counters, output registers) lives in the top module.

## Test plan
All cases use DW=512 (BPB=64).
- L=64, tready=1: one beat; tkeep all ones; tlast=1; bytes 0x00..0x3F; packets_sent=1; first tvalid one cycle after command accept.
- L=130: three beats with tkeep ones/ones/0x3. Last beat bytes 0,1 = 0x80, 0x81, rest 0x00. tlast only on beat 3.
- L=0: err_zero_len high for one cycle, no output beat, packets_sent unchanged. A following L=1 produces a single beat with tkeep=0x1, byte 0 = 0x00, tlast=1.
- L=200 with tready pattern 1,0,0,1,0,1,1: four beats, each held stable across stalls. Last tkeep = 0xFF (8 bytes), last beat byte 0 = 0xC0.
- Back-to-back commands L=300 then L=65535 with cmd_tvalid held:
  - First packet is 5 beats; beat 4 byte 0 = 0x00 (byte 256 wraps).
  - Exactly one idle cycle between the two packets.
  - Second packet is 1024 beats with final tkeep of 63 ones.
  - packets_sent=2.
- resetn low for one cycle during beat 3 of L=640: tvalid=0 next cycle, no tlast, packets_sent=0. A new L=64 command afterward completes normally.
